// File: rtl/counter_spi_port.sv
// SPI mode-0 slave giving a host preload/readback access to the 8-bit counter core.
// Pads are synchronized into clk; a frame is one cs_n-low window of WIDTH sclk rises.
module counter_spi_port #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_cs_n,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] load_value,
    output logic             load_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 2);
    localparam logic [CntW-1:0] BitsFull = CntW'(WIDTH);
    localparam logic [CntW-1:0] BitsSat  = CntW'(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    logic [SYNC_STG-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                cs_hist_q, sclk_hist_q;
    logic                cs_s, sclk_s, mosi_s;
    logic                cs_fall, cs_rise, sclk_rise, sclk_fall;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    tx_q, tx_d;
    logic [WIDTH-1:0]    rx_q, rx_d;
    logic [CntW-1:0]     bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]    load_value_q, load_value_d;
    logic                load_valid_q, load_valid_d;
    logic                frame_err_q, frame_err_d;

    assign cs_s   = cs_sync_q[SYNC_STG-1];
    assign sclk_s = sclk_sync_q[SYNC_STG-1];
    assign mosi_s = mosi_sync_q[SYNC_STG-1];

    // Clearing the cs_n chain to 0 means a host already holding cs_n low at reset
    // release produces no falling edge, so no frame starts until a fresh fall.
    assign cs_fall   = cs_hist_q & ~cs_s;
    assign cs_rise   = ~cs_hist_q & cs_s;
    assign sclk_rise = ~sclk_hist_q & sclk_s;
    assign sclk_fall = sclk_hist_q & ~sclk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_hist_q   <= 1'b0;
            sclk_hist_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STG-2:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], spi_mosi};
            cs_hist_q   <= cs_s;
            sclk_hist_q <= sclk_s;
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        bitcnt_d     = bitcnt_q;
        load_value_d = load_value_q;
        load_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    tx_d     = count_in;
                    bitcnt_d = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                // cs_n rise has priority over any sclk edge detected in the same cycle
                if (cs_rise) begin
                    state_d = StDone;
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[WIDTH-2:0], mosi_s};
                        if (bitcnt_q != BitsSat) begin
                            bitcnt_d = bitcnt_q + CntW'(1);
                        end
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            StDone: begin
                if (bitcnt_q == BitsFull) begin
                    load_value_d = rx_q;
                    load_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tx_q         <= '0;
            rx_q         <= '0;
            bitcnt_q     <= '0;
            load_value_q <= '0;
            load_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            bitcnt_q     <= bitcnt_d;
            load_value_q <= load_value_d;
            load_valid_q <= load_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign busy       = (state_q == StShift);
    assign spi_miso   = busy ? tx_q[WIDTH-1] : 1'b0;
    assign load_value = load_value_q;
    assign load_valid = load_valid_q;
    assign frame_err  = frame_err_q;

endmodule
